// File: rtl/cam_capture.sv
// -----------------------------------------------------------------------------
// cam_capture
//   Captures pixels from an 8-bit parallel camera bus (RGB565 byte pairs),
//   decodes each pair to either RGB444 (DATA_WIDTH=12) or 4-bit luma
//   (DATA_WIDTH=4), and writes them into a FIFO that runs on the camera clock.
//   After capture is enabled, SKIP_FRAMES whole frames are discarded so the
//   sensor can settle.
//
//   Optional feature: define CAM_CAPTURE_STATS_EN to build the saturating
//   dropped-pixel counter. Without it drop_cnt is tied to zero.
//
// Ports
//   wclk        camera PCLK, sole clock and FIFO write clock
//   wrst_n      asynchronous active-low reset
//   cap_en      capture enable (wclk domain)
//   vsync       camera VSYNC, high during vertical blanking
//   href        camera HREF, high while line bytes are valid
//   cam_data    camera data byte
//   full        FIFO full flag (wclk domain)
//   w_en        registered FIFO write strobe, one cycle per pixel
//   data_out    registered pixel, valid while w_en=1
//   frame_done  one-cycle pulse at the end of each captured frame
//   overflow    sticky: a pixel was dropped in the current frame
//   drop_cnt    total dropped pixels (zero when the stats build is off)
//   dbg_state   current FSM state (0 IDLE, 1 WAIT_VS, 2 CAPTURE)
//
// Handshake: the FIFO accepts data_out in every cycle where w_en=1. There is
//   no back-pressure on the camera side; a pixel that completes while full=1
//   is dropped, never delayed.
// -----------------------------------------------------------------------------
module cam_capture #(
  parameter int DATA_WIDTH  = 4,
  parameter int SKIP_FRAMES = 2
) (
  input  logic                  wclk,
  input  logic                  wrst_n,
  input  logic                  cap_en,
  input  logic                  vsync,
  input  logic                  href,
  input  logic [7:0]            cam_data,
  input  logic                  full,
  output logic                  w_en,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  frame_done,
  output logic                  overflow,
  output logic [15:0]           drop_cnt,
  output logic [1:0]            dbg_state
);

  generate
    if (!(DATA_WIDTH == 4 || DATA_WIDTH == 12)) begin : g_bad_width
      $error("cam_capture: DATA_WIDTH must be 4 or 12");
    end
    if (SKIP_FRAMES < 0 || SKIP_FRAMES > 15) begin : g_bad_skip
      $error("cam_capture: SKIP_FRAMES must be in 0..15");
    end
  endgenerate

  localparam logic [3:0] SKIP_LAST = SKIP_FRAMES[3:0];

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_VS = 2'd1,
    CAPTURE = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic [3:0]              skip_cnt_q, skip_cnt_d;
  logic                    phase_q, phase_d;
  logic                    vsync_q;
  logic [7:0]              byte0_q, byte0_d;
  logic                    w_en_q, w_en_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic                    frame_done_q, frame_done_d;
  logic                    overflow_q, overflow_d;

  logic vs_fall, vs_rise;
  assign vs_fall = vsync_q & ~vsync;
  assign vs_rise = ~vsync_q & vsync;

  // RGB565 -> 4/4/4 components; byte0 is the stored first byte, byte1 is the
  // byte on the bus in the cycle that completes the pixel.
  logic [3:0] r4, g4, b4;
  assign r4 = byte0_q[7:4];
  assign g4 = {byte0_q[2:0], cam_data[7]};
  assign b4 = cam_data[4:1];

  logic [DATA_WIDTH-1:0] pixel;
  generate
    if (DATA_WIDTH == 12) begin : g_rgb444
      assign pixel = {r4, g4, b4};
    end else begin : g_mono
      // Luma approximation R + 2G + B (max 60, fits 6 bits), keep top 4 bits.
      assign pixel = 4'(({2'b00, r4} + {1'b0, g4, 1'b0} + {2'b00, b4}) >> 2);
    end
  endgenerate

  // Bits of the RGB565 pair that the 4/4/4 decode does not use.
  logic unused_bits;
  assign unused_bits = ^{cam_data[6:5], cam_data[0], byte0_q[3]};

  // A pixel completes when the second byte of a pair is sampled in CAPTURE
  // and the frame is not ending on this same edge.
  logic pix_done;
  assign pix_done = (state_q == CAPTURE) && !vs_rise && href && phase_q;

  always_comb begin
    state_d      = state_q;
    skip_cnt_d   = skip_cnt_q;
    phase_d      = phase_q;
    byte0_d      = byte0_q;
    w_en_d       = 1'b0;
    data_d       = data_q;
    frame_done_d = 1'b0;
    overflow_d   = overflow_q;

    case (state_q)
      IDLE: begin
        if (cap_en) begin
          state_d    = WAIT_VS;
          skip_cnt_d = 4'd0;
        end
      end

      WAIT_VS: begin
        if (!cap_en) begin
          state_d = IDLE;
        end else if (vs_fall) begin
          if (skip_cnt_q == SKIP_LAST) begin
            state_d    = CAPTURE;
            overflow_d = 1'b0;
            phase_d    = 1'b0;
          end else begin
            skip_cnt_d = skip_cnt_q + 4'd1;
          end
        end
      end

      CAPTURE: begin
        if (vs_rise) begin
          // Frame end wins over any half-formed pixel, which is discarded.
          frame_done_d = 1'b1;
          phase_d      = 1'b0;
          state_d      = cap_en ? WAIT_VS : IDLE;
        end else if (href) begin
          if (!phase_q) begin
            byte0_d = cam_data;
            phase_d = 1'b1;
          end else begin
            phase_d = 1'b0;
            if (full) begin
              overflow_d = 1'b1;
            end else begin
              w_en_d = 1'b1;
              data_d = pixel;
            end
          end
        end else begin
          // Line gap: an odd trailing byte is dropped here.
          phase_d = 1'b0;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      state_q      <= IDLE;
      skip_cnt_q   <= 4'd0;
      phase_q      <= 1'b0;
      vsync_q      <= 1'b0;
      byte0_q      <= 8'd0;
      w_en_q       <= 1'b0;
      data_q       <= '0;
      frame_done_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      skip_cnt_q   <= skip_cnt_d;
      phase_q      <= phase_d;
      vsync_q      <= vsync;
      byte0_q      <= byte0_d;
      w_en_q       <= w_en_d;
      data_q       <= data_d;
      frame_done_q <= frame_done_d;
      overflow_q   <= overflow_d;
    end
  end

`ifdef CAM_CAPTURE_STATS_EN
  logic [15:0] drop_cnt_q;
  logic        drop_pix;
  assign drop_pix = pix_done & full;

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      drop_cnt_q <= 16'h0000;
    end else if (drop_pix && (drop_cnt_q != 16'hFFFF)) begin
      drop_cnt_q <= drop_cnt_q + 16'd1;
    end
  end

  assign drop_cnt = drop_cnt_q;
`else
  logic unused_pix_done;
  assign unused_pix_done = pix_done;
  assign drop_cnt        = 16'h0000;
`endif

  assign w_en       = w_en_q;
  assign data_out   = data_q;
  assign frame_done = frame_done_q;
  assign overflow   = overflow_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_cam_capture.sv
// -----------------------------------------------------------------------------
// tb_cam_capture
//   Three instances share one stimulus stream:
//     u_a : DATA_WIDTH=12, SKIP_FRAMES=0
//     u_b : DATA_WIDTH=4,  SKIP_FRAMES=0
//     u_c : DATA_WIDTH=4,  SKIP_FRAMES=2
//   Inputs change just after a falling edge; outputs are read on the
//   falling edge, away from the rising (active) edge.
// -----------------------------------------------------------------------------
module tb_cam_capture;

  // ---------------- clock / reset ----------------
  logic wclk = 1'b0;
  always #5 wclk = ~wclk;

  logic       wrst_n, cap_en, vsync, href, full;
  logic [7:0] cam_data;

  logic        a_w_en, a_fd, a_ovf;
  logic [11:0] a_data;
  logic [15:0] a_drop;
  logic [1:0]  a_st;
  logic        b_w_en, b_fd, b_ovf;
  logic [3:0]  b_data;
  logic [15:0] b_drop;
  logic [1:0]  b_st;
  logic        c_w_en, c_fd, c_ovf;
  logic [3:0]  c_data;
  logic [15:0] c_drop;
  logic [1:0]  c_st;

  cam_capture #(.DATA_WIDTH(12), .SKIP_FRAMES(0)) u_a (
    .wclk(wclk), .wrst_n(wrst_n), .cap_en(cap_en), .vsync(vsync), .href(href),
    .cam_data(cam_data), .full(full), .w_en(a_w_en), .data_out(a_data),
    .frame_done(a_fd), .overflow(a_ovf), .drop_cnt(a_drop), .dbg_state(a_st));

  cam_capture #(.DATA_WIDTH(4), .SKIP_FRAMES(0)) u_b (
    .wclk(wclk), .wrst_n(wrst_n), .cap_en(cap_en), .vsync(vsync), .href(href),
    .cam_data(cam_data), .full(full), .w_en(b_w_en), .data_out(b_data),
    .frame_done(b_fd), .overflow(b_ovf), .drop_cnt(b_drop), .dbg_state(b_st));

  cam_capture #(.DATA_WIDTH(4), .SKIP_FRAMES(2)) u_c (
    .wclk(wclk), .wrst_n(wrst_n), .cap_en(cap_en), .vsync(vsync), .href(href),
    .cam_data(cam_data), .full(full), .w_en(c_w_en), .data_out(c_data),
    .frame_done(c_fd), .overflow(c_ovf), .drop_cnt(c_drop), .dbg_state(c_st));

`ifdef CAM_CAPTURE_STATS_EN
  localparam logic [31:0] EXP_DROP = 32'd3;
`else
  localparam logic [31:0] EXP_DROP = 32'd0;
`endif

  // ---------------- vectors ----------------
  typedef struct {
    logic [7:0]  b0;
    logic [7:0]  b1;
    logic [11:0] exp12;
    logic [3:0]  exp4;
  } vec_t;

  vec_t vecs[7];

  // ---------------- scoreboard state ----------------
  int         checks = 0;
  int         errors = 0;
  int         wr_a = 0, wr_b = 0, wr_c = 0, fd_a = 0, fd_c = 0;
  logic [3:0] got_c[$];
  logic [3:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Advance one cycle and record what the DUTs produced on it.
  task automatic tick();
    @(negedge wclk);
    if (a_w_en) wr_a++;
    if (b_w_en) wr_b++;
    if (c_w_en) begin
      wr_c++;
      got_c.push_back(c_data);
    end
    if (a_fd) fd_a++;
    if (c_fd) fd_c++;
  endtask

  // ---------------- driver tasks ----------------
  task automatic frame_start();
    href  = 1'b0;
    vsync = 1'b1;
    tick();
    tick();
    vsync = 1'b0;
    tick();
    tick();
  endtask

  task automatic frame_end();
    href  = 1'b0;
    vsync = 1'b1;
    tick();
  endtask

  task automatic send_byte(input logic [7:0] b);
    href     = 1'b1;
    cam_data = b;
    tick();
  endtask

  task automatic send_pixel(input int i);
    send_byte(vecs[i].b0);
    send_byte(vecs[i].b1);
  endtask

  task automatic line_gap();
    href = 1'b0;
    tick();
    tick();
  endtask

  // ---------------- test ----------------
  initial begin
    int base_a, base_c, base_fd;

    vecs[0] = '{8'hF8, 8'h1F, 12'hF0F, 4'h7};
    vecs[1] = '{8'h07, 8'hE0, 12'h0F0, 4'h7};
    vecs[2] = '{8'hFF, 8'hFF, 12'hFFF, 4'hF};
    vecs[3] = '{8'h84, 8'h10, 12'h888, 4'h8};
    vecs[4] = '{8'h00, 8'h00, 12'h000, 4'h0};
    vecs[5] = '{8'h53, 8'h9A, 12'h57D, 4'h8};
    vecs[6] = '{8'h2C, 8'h46, 12'h283, 4'h5};

    wrst_n = 1'b0; cap_en = 1'b0; vsync = 1'b0; href = 1'b0;
    full = 1'b0; cam_data = 8'h00;
    tick();
    tick();

    // Reset state
    check("rst_w_en", a_w_en, 0);
    check("rst_data", a_data, 0);
    check("rst_fd", a_fd, 0);
    check("rst_ovf", a_ovf, 0);
    check("rst_drop", a_drop, 0);
    check("rst_state", a_st, 0);
    check("rst_c_data", c_data, 0);

    wrst_n = 1'b1;
    tick();
    check("idle_hold", a_st, 0);
    cap_en = 1'b1;
    tick();
    check("to_wait_vs", a_st, 1);

    // Frame 1: table of pixels on one line
    frame_start();
    check("f1_capture", a_st, 2);
    check("f1_c_skip", c_st, 1);
    for (int i = 0; i < 7; i++) begin
      href     = 1'b1;
      cam_data = vecs[i].b0;
      tick();
      check($sformatf("v%0d_b0_no_wen", i), a_w_en, 0);
      cam_data = vecs[i].b1;
      tick();
      check($sformatf("v%0d_a_wen", i), a_w_en, 1);
      check($sformatf("v%0d_a_data", i), a_data, vecs[i].exp12);
      check($sformatf("v%0d_b_data", i), b_data, vecs[i].exp4);
      check($sformatf("v%0d_c_wen", i), c_w_en, 0);
    end
    frame_end();
    check("f1_a_fd", a_fd, 1);
    check("f1_c_fd", c_fd, 0);
    tick();
    check("f1_fd_one_cycle", a_fd, 0);
    check("f1_back_wait", a_st, 1);
    check("f1_a_writes", wr_a, 7);
    check("f1_b_writes", wr_b, 7);

    // Frame 2: still settling for u_c
    base_c = wr_c;
    frame_start();
    for (int i = 0; i < 4; i++) send_pixel(i);
    frame_end();
    tick();
    check("f2_c_writes", wr_c - base_c, 0);
    check("f2_c_fd", fd_c, 0);

    // Frame 3: u_c captures
    got_c.delete();
    for (int i = 0; i < 4; i++) exp_q.push_back(vecs[i].exp4);
    base_c = wr_c;
    frame_start();
    for (int i = 0; i < 4; i++) send_pixel(i);
    frame_end();
    tick();
    check("f3_c_writes", wr_c - base_c, 4);
    check("f3_c_fd", fd_c, 1);
    check("f3_c_pix_cnt", got_c.size(), 4);
    while (exp_q.size() > 0 && got_c.size() > 0) begin
      check("f3_c_pix", got_c.pop_front(), exp_q.pop_front());
    end

    // Frame 4: FIFO full for 3 pixels
    frame_start();
    check("f4_ovf_start", a_ovf, 0);
    full   = 1'b1;
    base_a = wr_a;
    for (int i = 0; i < 3; i++) send_pixel(i);
    check("f4_no_writes", wr_a - base_a, 0);
    check("f4_a_ovf", a_ovf, 1);
    check("f4_c_ovf", c_ovf, 1);
    check("f4_a_drop", a_drop, EXP_DROP);
    full = 1'b0;
    send_pixel(2);
    check("f4_resume_wen", a_w_en, 1);
    check("f4_resume_data", a_data, 12'hFFF);
    check("f4_ovf_sticky", a_ovf, 1);
    frame_end();
    tick();

    // Frame 5: overflow cleared, odd trailing byte dropped
    frame_start();
    check("f5_ovf_clear", a_ovf, 0);
    check("f5_drop_kept", a_drop, EXP_DROP);
    base_a = wr_a;
    send_pixel(0);
    send_pixel(1);
    send_byte(8'hAA);
    line_gap();
    check("f5_odd_writes", wr_a - base_a, 2);
    send_pixel(3);
    check("f5_realign_wen", a_w_en, 1);
    check("f5_realign_data", a_data, 12'h888);
    frame_end();
    tick();

    // Frame 6: vsync rises mid-pixel
    frame_start();
    base_a  = wr_a;
    base_fd = fd_a;
    send_byte(vecs[5].b0);
    href     = 1'b1;
    cam_data = vecs[5].b1;
    vsync    = 1'b1;
    tick();
    check("f6_partial_wen", a_w_en, 0);
    check("f6_fd", a_fd, 1);
    href = 1'b0;
    tick();
    check("f6_writes", wr_a - base_a, 0);
    check("f6_fd_cnt", fd_a - base_fd, 1);

    // Frame 7: cap_en dropped mid-frame, frame still completes
    frame_start();
    base_a = wr_a;
    send_pixel(6);
    cap_en = 1'b0;
    send_pixel(5);
    check("f7_wen_after_off", a_w_en, 1);
    check("f7_data_after_off", a_data, 12'h57D);
    frame_end();
    check("f7_fd", a_fd, 1);
    tick();
    check("f7_idle", a_st, 0);
    check("f7_writes", wr_a - base_a, 2);

    // Frame 8: disabled, nothing happens
    base_a  = wr_a;
    base_fd = fd_a;
    frame_start();
    send_pixel(2);
    send_pixel(3);
    frame_end();
    tick();
    check("f8_writes", wr_a - base_a, 0);
    check("f8_fd", fd_a - base_fd, 0);
    check("f8_idle", a_st, 0);

    // Frame 9: reset in the middle of a line
    cap_en = 1'b1;
    tick();
    frame_start();
    full = 1'b1;
    send_pixel(0);
    full = 1'b0;
    send_pixel(2);
    check("f9_pre_rst_wen", a_w_en, 1);
    check("f9_pre_rst_ovf", a_ovf, 1);
    wrst_n = 1'b0;
    #1;
    check("f9_rst_wen", a_w_en, 0);
    check("f9_rst_data", a_data, 0);
    check("f9_rst_ovf", a_ovf, 0);
    check("f9_rst_drop", a_drop, 0);
    check("f9_rst_state", a_st, 0);
    href = 1'b0;
    tick();
    wrst_n = 1'b1;
    tick();
    tick();

    // Frames 10-12: settling restarts after reset
    for (int f = 0; f < 3; f++) begin
      base_a = wr_a;
      base_c = wr_c;
      frame_start();
      send_pixel(f);
      frame_end();
      tick();
      check($sformatf("post_rst_f%0d_a", f), wr_a - base_a, 1);
      check($sformatf("post_rst_f%0d_c", f), wr_c - base_c, (f == 2) ? 1 : 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Guard against a stuck simulation.
  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
